// File: rtl/usb_dma_pkg.sv
// rtl/usb_dma_pkg.sv - shared state encodings and bus constants for the USB EP2 to Wishbone loader
package usb_dma_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    FLUSH    = 3'd2,
    WAIT_ACK = 3'd3,
    DONE     = 3'd4
  } dma_state_t;

  localparam logic [3:0] SEL_LO   = 4'b0011;
  localparam logic [3:0] SEL_ALL  = 4'b1111;
  localparam logic [1:0] EP2_ADDR = 2'b00;

endpackage

// File: rtl/usb_word_fifo.sv
// rtl/usb_word_fifo.sv - synchronous word buffer; pops one or two words per cycle
module usb_word_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  input  logic                   pop_two,
  output logic [WIDTH-1:0]       dout,
  output logic [WIDTH-1:0]       dout_next,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_next;
  logic [AW:0]      pop_n;

  assign pop_n       = pop_two ? (AW+1)'(2) : (pop ? (AW+1)'(1) : '0);
  assign rd_ptr_next = rd_ptr + AW'(1);
  assign dout        = mem[rd_ptr];
  assign dout_next   = mem[rd_ptr_next];
  assign empty       = (count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr + pop_n[AW-1:0];
      count  <= count + (AW+1)'(push) - pop_n;
    end
  end

endmodule

// File: rtl/usb_ep_to_wb_dma.sv
// rtl/usb_ep_to_wb_dma.sv - FX2LP EP2 OUT words buffered and written as Wishbone beats
// Defining USB_DMA_CHECKSUM_EN adds the 16-bit checksum output.
module usb_ep_to_wb_dma
  import usb_dma_pkg::*;
#(
  parameter int          NUM_WORDS = 118,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'd1,
  parameter int          BUF_DEPTH = 8,
  parameter int          PACK      = 0
) (
  input  logic        CLKOUT,
  input  logic        rst,
  input  logic        start,
  input  logic        FLAGA,
  input  logic [15:0] FDATA,
  output logic        SLRD,
  output logic        SLOE,
  output logic        SLWR,
  output logic        IFCLK,
  output logic [1:0]  FIFOADR,
  input  logic        stall_o,
  input  logic        sdram_ack,
  output logic        cyc_i,
  output logic        stb_i,
  output logic        we_i,
  output logic [3:0]  sel_i,
  output logic [31:0] addr_i,
  output logic [31:0] data_i,
  output logic        busy,
  output logic        done,
`ifdef USB_DMA_CHECKSUM_EN
  output logic [15:0] checksum,
`endif
  output logic [15:0] word_cnt
);

  localparam int            CW       = $clog2(BUF_DEPTH) + 1;
  localparam logic [15:0]   NW       = 16'(NUM_WORDS);
  localparam logic [CW-1:0] RD_LIMIT = CW'(BUF_DEPTH - 1);

  dma_state_t    state, state_nxt;
  logic [15:0]   head, head_next;
  logic [CW-1:0] occ;
  logic          empty, rd_en, in_job, outst;
  logic          pair_ready, beat_ready, accept, beat_done, beat_load;
  logic          pop_one, pop_two;

  assign SLWR    = 1'b1;
  assign IFCLK   = ~CLKOUT;
  assign FIFOADR = EP2_ADDR;
  assign we_i    = cyc_i;

  assign in_job = (state == READ) || (state == FLUSH);
  // One slot is kept free so a read strobed this cycle always has room.
  assign rd_en  = (state == READ) && FLAGA && (word_cnt < NW) && (occ < RD_LIMIT);

  usb_word_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(16)) u_buf (
    .clk      (CLKOUT),
    .rst      (rst),
    .push     (rd_en),
    .din      (FDATA),
    .pop      (pop_one),
    .pop_two  (pop_two),
    .dout     (head),
    .dout_next(head_next),
    .count    (occ),
    .empty    (empty)
  );

  always_comb begin
    pair_ready = 1'b0;
    beat_ready = !empty;
    if (PACK != 0) begin
      pair_ready = (occ >= CW'(2));
      beat_ready = pair_ready || ((word_cnt == NW) && (occ == CW'(1)));
    end
  end

  assign accept    = stb_i && !stall_o;
  assign beat_done = sdram_ack && (accept || outst);
  assign beat_load = in_job && beat_ready && (!cyc_i || beat_done);
  assign pop_two   = beat_load && pair_ready;
  assign pop_one   = beat_load && !pair_ready;

  always_ff @(posedge CLKOUT) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    SLRD      = ~rd_en;
    SLOE      = 1'b1;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:     if (start) state_nxt = READ;
      READ: begin
        SLOE = 1'b0;
        busy = 1'b1;
        if ((word_cnt == NW) || (rd_en && (word_cnt == NW - 16'd1))) state_nxt = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (empty && !cyc_i) state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        busy = 1'b1;
        if (!outst) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLKOUT) begin
    if (rst) begin
      word_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      word_cnt <= '0;
    end else if (rd_en) begin
      word_cnt <= word_cnt + 16'd1;
    end
  end

`ifdef USB_DMA_CHECKSUM_EN
  always_ff @(posedge CLKOUT) begin
    if (rst || ((state == IDLE) && start)) checksum <= '0;
    else if (rd_en)                        checksum <= checksum + FDATA;
  end
`endif

  // Single outstanding beat: later assignments in this block take priority.
  always_ff @(posedge CLKOUT) begin
    if (rst) begin
      cyc_i  <= 1'b0;
      stb_i  <= 1'b0;
      outst  <= 1'b0;
      sel_i  <= '0;
      addr_i <= BASE_ADDR;
      data_i <= '0;
    end else begin
      if ((state == IDLE) && start) addr_i <= BASE_ADDR;
      outst <= (outst || accept) && !sdram_ack;
      if (accept) stb_i <= 1'b0;
      if (beat_done) begin
        addr_i <= addr_i + ADDR_STEP;
        cyc_i  <= 1'b0;
      end
      if (beat_load) begin
        cyc_i  <= 1'b1;
        stb_i  <= 1'b1;
        data_i <= pair_ready ? {head_next, head} : {16'h0000, head};
        sel_i  <= pair_ready ? SEL_ALL : SEL_LO;
      end
    end
  end

endmodule

// File: tb/tb_usb_ep_to_wb_dma.sv
// tb/tb_usb_ep_to_wb_dma.sv - directed bench: three loader instances (4 words, 5 words packed, 118 words)
module tb_usb_ep_to_wb_dma;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        flaga = 1'b0;
  logic        stall = 1'b0;
  logic        ack = 1'b0;
  logic [15:0] fdata = 16'h0;
  logic        start [3];

  logic        slrd [3], sloe [3], slwr [3], ifclk [3];
  logic [1:0]  fifoadr [3];
  logic        cyc [3], stb [3], we [3], busy [3], done [3];
  logic [3:0]  sel [3];
  logic [31:0] addr [3], data [3];
  logic [15:0] wcnt [3];
`ifdef USB_DMA_CHECKSUM_EN
  logic [15:0] csum [3];
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    usb_ep_to_wb_dma #(
      .NUM_WORDS((g == 0) ? 4 : ((g == 1) ? 5 : 118)),
      .BASE_ADDR(32'h0000_0000),
      .ADDR_STEP(32'd1),
      .BUF_DEPTH(8),
      .PACK((g == 1) ? 1 : 0)
    ) dut (
      .CLKOUT   (clk),
      .rst      (rst),
      .start    (start[g]),
      .FLAGA    (flaga),
      .FDATA    (fdata),
      .SLRD     (slrd[g]),
      .SLOE     (sloe[g]),
      .SLWR     (slwr[g]),
      .IFCLK    (ifclk[g]),
      .FIFOADR  (fifoadr[g]),
      .stall_o  (stall),
      .sdram_ack(ack),
      .cyc_i    (cyc[g]),
      .stb_i    (stb[g]),
      .we_i     (we[g]),
      .sel_i    (sel[g]),
      .addr_i   (addr[g]),
      .data_i   (data[g]),
      .busy     (busy[g]),
      .done     (done[g]),
`ifdef USB_DMA_CHECKSUM_EN
      .checksum (csum[g]),
`endif
      .word_cnt (wcnt[g])
    );
  end

  int passed = 0;
  int total = 0;

  logic [15:0] src [$];
  logic [31:0] b_addr [$];
  logic [31:0] b_data [$];
  logic [3:0]  b_sel [$];
  int reads, acc, done_cnt, done_cycle, last_ack_cycle, reads_at_release;
  logic [15:0] csum_at_done;

  // Cycle-based source/sink model: inputs set at negedge, outputs sampled 1 time unit later.
  task automatic run_job(input int d, input int toggle, input int stall_n,
                         input int max_acc, input int budget, input int start_again);
    int idx = 0;
    int stall_left = stall_n;
    bit ack_pend = 1'b0;
    b_addr.delete(); b_data.delete(); b_sel.delete();
    reads = 0; acc = 0; done_cnt = 0; done_cycle = -1; last_ack_cycle = -1;
    reads_at_release = -1; csum_at_done = 16'h0;
    @(negedge clk);
    start[d] = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      start[d] = (c == start_again);
      flaga = (toggle == 0) ? 1'b1 : (((c / 3) % 2) == 0);
      ack = ack_pend;
      if (ack_pend) last_ack_cycle = c;
      ack_pend = 1'b0;
      fdata = (idx < src.size()) ? src[idx] : 16'h0;
      if (stb[d] && stall_left > 0) begin
        stall = 1'b1;
        stall_left--;
        if (stall_left == 0) reads_at_release = reads;
      end else begin
        stall = 1'b0;
      end
      #1;
      if (!slrd[d]) begin reads++; idx++; end
      if (cyc[d] && stb[d] && !stall) begin
        b_addr.push_back(addr[d]);
        b_data.push_back(data[d]);
        b_sel.push_back(sel[d]);
        acc++;
        ack_pend = 1'b1;
      end
      if (done[d]) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = c;
`ifdef USB_DMA_CHECKSUM_EN
        csum_at_done = csum[d];
`endif
      end
      if (max_acc > 0 && acc >= max_acc) break;
      if (done_cycle >= 0 && c >= done_cycle + 3) break;
    end
    start[d] = 1'b0;
    ack = 1'b0;
    stall = 1'b0;
  endtask

  function automatic int bad_plain_beats();
    int bad = 0;
    for (int i = 0; i < b_data.size(); i++)
      if (b_addr[i] !== 32'(i) || b_data[i] !== {16'h0, src[i]} || b_sel[i] !== 4'b0011) bad++;
    return bad;
  endfunction

  task automatic fill_src(input int n, input logic [15:0] seed);
    src.delete();
    for (int i = 0; i < n; i++) src.push_back(seed ^ 16'(i * 16'h0101 + 3));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({slrd[0], sloe[0], cyc[0], stb[0], busy[0], done[0], slwr[0], ifclk[0], we[0]} !== 9'b110000110)
      $display("FAIL reset_ctrl got %b want 110000110",
               {slrd[0], sloe[0], cyc[0], stb[0], busy[0], done[0], slwr[0], ifclk[0], we[0]});
    else passed++;
    total++;
    if ({sel[0], fifoadr[0]} !== 6'b0) $display("FAIL reset_sel_fifoadr got %b want 0", {sel[0], fifoadr[0]});
    else passed++;
    total++;
    if (addr[0] !== 32'h0 || data[0] !== 32'h0) $display("FAIL reset_addr_data got %h/%h want 0/0", addr[0], data[0]);
    else passed++;
    total++;
    if (wcnt[2] !== 16'h0 || cyc[2] !== 1'b0 || busy[1] !== 1'b0)
      $display("FAIL reset_others got wcnt=%h cyc=%b busy=%b want 0/0/0", wcnt[2], cyc[2], busy[1]);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_pack0();
    src = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    run_job(0, 0, 0, 0, 200, -1);
    total++;
    if (acc !== 4) $display("FAIL p0_beats got %0d want 4", acc); else passed++;
    for (int i = 0; i < 4 && i < acc; i++) begin
      total++;
      if (b_addr[i] !== 32'(i) || b_data[i] !== 32'(i + 1) || b_sel[i] !== 4'b0011)
        $display("FAIL p0_beat%0d got %h/%h/%b want %h/%h/0011", i, b_addr[i], b_data[i], b_sel[i], i, i + 1);
      else passed++;
    end
    total++;
    if (done_cnt !== 1) $display("FAIL p0_done_count got %0d want 1", done_cnt); else passed++;
    total++;
    if (done_cycle !== last_ack_cycle + 3)
      $display("FAIL p0_done_timing got %0d want %0d", done_cycle, last_ack_cycle + 3);
    else passed++;
    total++;
    if (wcnt[0] !== 16'd4 || reads !== 4) $display("FAIL p0_word_cnt got %0d/%0d want 4/4", wcnt[0], reads);
    else passed++;
  endtask

  task automatic test_pack1();
    logic [31:0] exp_d [3];
    logic [3:0]  exp_s [3];
    exp_d = '{32'h00A2_00A1, 32'h00A4_00A3, 32'h0000_00A5};
    exp_s = '{4'b1111, 4'b1111, 4'b0011};
    src = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4, 16'h00A5};
    run_job(1, 0, 0, 0, 200, -1);
    total++;
    if (acc !== 3) $display("FAIL p1_beats got %0d want 3", acc); else passed++;
    for (int i = 0; i < 3 && i < acc; i++) begin
      total++;
      if (b_addr[i] !== 32'(i) || b_data[i] !== exp_d[i] || b_sel[i] !== exp_s[i])
        $display("FAIL p1_beat%0d got %h/%h/%b want %h/%h/%b", i, b_addr[i], b_data[i], b_sel[i], i, exp_d[i], exp_s[i]);
      else passed++;
    end
    total++;
    if (done_cnt !== 1 || wcnt[1] !== 16'd5) $display("FAIL p1_done got %0d/%0d want 1/5", done_cnt, wcnt[1]);
    else passed++;
  endtask

  task automatic test_stall();
    fill_src(118, 16'h5A00);
    run_job(2, 0, 10, 0, 2000, -1);
    total++;
    if (reads_at_release !== 8) $display("FAIL stall_fill got %0d want 8", reads_at_release); else passed++;
    total++;
    if (acc !== 118) $display("FAIL stall_beats got %0d want 118", acc); else passed++;
    total++;
    if (bad_plain_beats() !== 0) $display("FAIL stall_data got %0d bad beats want 0", bad_plain_beats());
    else passed++;
    total++;
    if (done_cnt !== 1) $display("FAIL stall_done got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_flaga_toggle();
    fill_src(118, 16'hC3C3);
    run_job(2, 1, 0, 0, 3000, 20);
    total++;
    if (reads !== 118 || wcnt[2] !== 16'd118) $display("FAIL tog_reads got %0d/%0d want 118/118", reads, wcnt[2]);
    else passed++;
    total++;
    if (acc !== 118) $display("FAIL tog_beats got %0d want 118", acc); else passed++;
    total++;
    if (bad_plain_beats() !== 0) $display("FAIL tog_data got %0d bad beats want 0", bad_plain_beats());
    else passed++;
    total++;
    if (done_cnt !== 1 || done_cycle !== last_ack_cycle + 3)
      $display("FAIL tog_done got cnt=%0d cyc=%0d want 1/%0d", done_cnt, done_cycle, last_ack_cycle + 3);
    else passed++;
  endtask

  task automatic test_reset_mid_job();
    fill_src(118, 16'h0F0F);
    run_job(2, 0, 0, 3, 500, -1);
    total++;
    if (acc !== 3) $display("FAIL rst_pre_beats got %0d want 3", acc); else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if ({cyc[2], stb[2], busy[2], slrd[2], sloe[2]} !== 5'b00011)
      $display("FAIL rst_abort got %b want 00011", {cyc[2], stb[2], busy[2], slrd[2], sloe[2]});
    else passed++;
    rst = 1'b0;
    fill_src(118, 16'h7E81);
    run_job(2, 0, 0, 0, 2000, -1);
    total++;
    if (acc !== 118 || b_addr[0] !== 32'h0) $display("FAIL rst_restart got %0d beats addr0=%h want 118/0", acc, b_addr[0]);
    else passed++;
    total++;
    if (bad_plain_beats() !== 0 || done_cnt !== 1)
      $display("FAIL rst_restart_data got %0d bad done=%0d want 0/1", bad_plain_beats(), done_cnt);
    else passed++;
  endtask

`ifdef USB_DMA_CHECKSUM_EN
  task automatic test_checksum();
    src = '{16'hFFFF, 16'h0002, 16'h0000, 16'h0000};
    run_job(0, 0, 0, 0, 200, -1);
    total++;
    if (csum_at_done !== 16'h0001) $display("FAIL checksum got %h want 0001", csum_at_done); else passed++;
  endtask
`endif

  initial begin
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    test_reset();
    test_pack0();
    test_pack1();
    test_stall();
    test_flaga_toggle();
    test_reset_mid_job();
`ifdef USB_DMA_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
